// File: rtl/exe_result_sched_pkg.sv
// Shared types for the execute result scheduler: bundle layout, sizing defaults
// and the position of the valid flag inside opid.
package exe_result_sched_pkg;

  localparam int EWD       = 4;
  localparam int NFU       = 5;
  localparam int OPID_W    = 16;
  localparam int DATA_W    = 32;
  localparam int VALID_BIT = 15;

  typedef struct packed {
    logic [OPID_W-1:0] opid;
    logic [DATA_W-1:0] data;
  } exe_bundle_t;

  function automatic logic bundle_valid(input exe_bundle_t b);
    return b.opid[VALID_BIT];
  endfunction

endpackage

// File: rtl/exe_result_sched_rr_slot_picker.sv
// Combinational scan: walks FUs from the start index (wrapping), lanes in order,
// and hands each valid request the next free output slot in ascending order.
module exe_result_sched_rr_slot_picker #(
  parameter int ewd = 4,
  parameter int nfu = 5
) (
  input  logic [nfu-1:0][ewd-1:0]                 i_req,
  input  logic [ewd-1:0]                          i_free,
  input  logic [$clog2(nfu)-1:0]                  i_start,
  output logic [nfu-1:0][ewd-1:0]                 o_claim,
  output logic [ewd-1:0]                          o_slot_hit,
  output logic [ewd-1:0][$clog2(nfu*ewd)-1:0]     o_slot_src
);

  localparam int SLW  = $clog2(ewd);
  localparam int CNTW = $clog2(ewd) + 1;
  localparam int SRCW = $clog2(nfu*ewd);

  logic [ewd-1:0][SLW-1:0] w_free_list;
  logic [CNTW-1:0]         w_free_cnt;

  // Compact the free mask into an ordered list of slot indices.
  always_comb begin
    w_free_list = '0;
    w_free_cnt  = '0;
    for (int k = 0; k < ewd; k++) begin
      if (i_free[k]) begin
        w_free_list[w_free_cnt[SLW-1:0]] = SLW'(k);
        w_free_cnt = w_free_cnt + CNTW'(1);
      end
    end
  end

  always_comb begin
    logic [CNTW-1:0] grant_cnt;
    int              fu;
    int              lane;
    o_claim    = '0;
    o_slot_hit = '0;
    o_slot_src = '0;
    grant_cnt  = '0;
    fu         = 0;
    lane       = 0;
    for (int s = 0; s < nfu*ewd; s++) begin
      fu   = int'(i_start) + (s / ewd);
      if (fu >= nfu) fu = fu - nfu;
      lane = s % ewd;
      if (i_req[fu][lane] && (grant_cnt < w_free_cnt)) begin
        o_claim[fu][lane]                                = 1'b1;
        o_slot_hit[w_free_list[grant_cnt[SLW-1:0]]]      = 1'b1;
        o_slot_src[w_free_list[grant_cnt[SLW-1:0]]]      = SRCW'(fu*ewd + lane);
        grant_cnt = grant_cnt + CNTW'(1);
      end
    end
  end

endmodule

// File: rtl/exe_result_sched.sv
// Result scheduler: claims FU responses into ewd registered writeback slots that
// hold until the ROB accepts them; rotating pointer plus starvation counters.
module exe_result_sched
  import exe_result_sched_pkg::*;
#(
  parameter int ewd    = EWD,
  parameter int nfu    = NFU,
  parameter int STARVE = 8
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic                              i_flush,
  input  exe_bundle_t [nfu-1:0][ewd-1:0]    i_fu_resp,
  output logic        [nfu-1:0][ewd-1:0]    o_fu_claim,
  input  logic        [ewd-1:0]             i_execute,
  output exe_bundle_t [ewd-1:0]             o_exe_bundle
);

  localparam int          FUW      = $clog2(nfu);
  localparam int          SRCW     = $clog2(nfu*ewd);
  localparam logic [3:0]  STARVE_C = 4'(STARVE);
  localparam logic [3:0]  CNT_MAX  = 4'hF;

  exe_bundle_t [ewd-1:0]     r_slot;
  logic [FUW-1:0]            r_ptr;
  logic [nfu-1:0][3:0]       r_cnt;

  logic [nfu-1:0][ewd-1:0]   w_req;
  logic [nfu-1:0][ewd-1:0]   w_claim;
  exe_bundle_t               w_flat [nfu*ewd];
  logic [ewd-1:0]            w_free;
  logic [ewd-1:0]            w_slot_hit;
  logic [ewd-1:0][SRCW-1:0]  w_slot_src;
  exe_bundle_t [ewd-1:0]     w_slot_next;
  logic [nfu-1:0]            w_left;
  logic [nfu-1:0][3:0]       w_cnt_next;
  logic                      w_starve_any;
  logic [FUW-1:0]            w_starve_fu;
  logic [FUW-1:0]            w_start;
  logic [FUW-1:0]            w_ptr_inc;

  genvar gi, gj;
  generate
    for (gi = 0; gi < nfu; gi++) begin : g_fu
      for (gj = 0; gj < ewd; gj++) begin : g_lane
        assign w_req[gi][gj]       = bundle_valid(i_fu_resp[gi][gj]);
        assign w_flat[gi*ewd + gj] = i_fu_resp[gi][gj];
      end
      // An FU still holding a valid, unclaimed lane has been denied this cycle.
      assign w_left[gi]     = |(w_req[gi] & ~w_claim[gi]);
      assign w_cnt_next[gi] = !w_left[gi]            ? 4'd0 :
                              (r_cnt[gi] == CNT_MAX) ? CNT_MAX :
                                                       r_cnt[gi] + 4'd1;
    end

    for (gi = 0; gi < ewd; gi++) begin : g_slot
      assign w_free[gi]      = !bundle_valid(r_slot[gi]) || i_execute[gi];
      assign w_slot_next[gi] = !w_free[gi]    ? r_slot[gi] :
                               w_slot_hit[gi] ? w_flat[w_slot_src[gi]] :
                                                '0;
    end
  endgenerate

  // Lowest-index starving FU wins the start position.
  always_comb begin
    w_starve_any = 1'b0;
    w_starve_fu  = '0;
    for (int f = nfu - 1; f >= 0; f--) begin
      if (r_cnt[f] >= STARVE_C) begin
        w_starve_any = 1'b1;
        w_starve_fu  = FUW'(f);
      end
    end
  end

  assign w_start   = w_starve_any ? w_starve_fu : r_ptr;
  assign w_ptr_inc = (r_ptr == FUW'(nfu - 1)) ? '0 : r_ptr + FUW'(1);

  exe_result_sched_rr_slot_picker #(
    .ewd (ewd),
    .nfu (nfu)
  ) u_picker (
    .i_req      (w_req),
    .i_free     (w_free),
    .i_start    (w_start),
    .o_claim    (w_claim),
    .o_slot_hit (w_slot_hit),
    .o_slot_src (w_slot_src)
  );

  assign o_fu_claim   = (i_flush || !i_rst_n) ? '0 : w_claim;
  assign o_exe_bundle = r_slot;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_slot <= '0;
      r_ptr  <= '0;
      r_cnt  <= '0;
    end else if (i_flush) begin
      r_slot <= '0;
      r_cnt  <= '0;
    end else begin
      r_slot <= w_slot_next;
      r_cnt  <= w_cnt_next;
      if (|w_left) r_ptr <= w_ptr_inc;
    end
  end

endmodule

// File: tb/tb_exe_result_sched.sv
// Directed bench for exe_result_sched: reset, back-pressure, oversubscription,
// starvation override, flush and accept-and-refill.
module tb_exe_result_sched;
  import exe_result_sched_pkg::*;

  localparam int NF = 5;
  localparam int EW = 4;

  logic                           clk = 1'b0;
  logic                           rst_n = 1'b0;
  logic                           flush = 1'b0;
  exe_bundle_t [NF-1:0][EW-1:0]   fu_resp;
  logic        [NF-1:0][EW-1:0]   fu_claim;
  logic        [EW-1:0]           execute;
  exe_bundle_t [EW-1:0]           exe_bundle;

  int n_tests = 0;
  int n_fail  = 0;

  exe_result_sched #(.ewd(EW), .nfu(NF), .STARVE(8)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_flush      (flush),
    .i_fu_resp    (fu_resp),
    .o_fu_claim   (fu_claim),
    .i_execute    (execute),
    .o_exe_bundle (exe_bundle)
  );

  always #5 clk = ~clk;

  function automatic exe_bundle_t mk(input logic [15:0] op);
    exe_bundle_t b;
    b.opid = op;
    b.data = {16'hDA7A, op};
    return b;
  endfunction

  task automatic clear_resp();
    fu_resp = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_resp();
    execute = '0;
    flush   = 1'b0;
    rst_n   = 1'b0;
    step();
    rst_n   = 1'b1;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    execute = '0;
    for (int f = 0; f < NF; f++)
      for (int l = 0; l < EW; l++)
        fu_resp[f][l] = mk(16'(32'h8000 + f*4 + l));
    step();
    n_tests++;
    if (fu_claim !== '0) begin
      n_fail++; $display("FAIL reset_claim: got %h expected %h", fu_claim, 20'h0);
    end
    n_tests++;
    if (exe_bundle !== '0) begin
      n_fail++; $display("FAIL reset_bundle: got %h expected 0", exe_bundle);
    end
    rst_n = 1'b1;
    #2;
    n_tests++;
    if (fu_claim !== 20'h0000F) begin
      n_fail++; $display("FAIL reset_first_claim: got %h expected %h", fu_claim, 20'h0000F);
    end
    step();
    for (int k = 0; k < EW; k++) begin
      n_tests++;
      if (exe_bundle[k] !== mk(16'(32'h8000 + k))) begin
        n_fail++; $display("FAIL reset_first_slot%0d: got %h expected %h", k, exe_bundle[k].opid, 16'(32'h8000 + k));
      end
    end
    $display("[TB] reset: first claim %h loaded", 20'h0000F);
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (exe_bundle !== '0) begin
      n_fail++; $display("FAIL reset_async_bundle: got %h expected 0", exe_bundle);
    end
    n_tests++;
    if (fu_claim !== '0) begin
      n_fail++; $display("FAIL reset_async_claim: got %h expected 0", fu_claim);
    end
    step();
    clear_resp();
    rst_n = 1'b1;
  endtask

  task automatic test_back_pressure();
    logic [15:0] exp_op [EW];
    do_reset();
    for (int l = 0; l < EW; l++) fu_resp[0][l] = mk(16'(32'h8010 + l));
    #2;
    n_tests++;
    if (fu_claim !== 20'h0000F) begin
      n_fail++; $display("FAIL bp_fill_claim: got %h expected %h", fu_claim, 20'h0000F);
    end
    step();
    clear_resp();
    for (int l = 0; l < EW; l++) fu_resp[1][l] = mk(16'(32'h8020 + l));
    for (int c = 0; c < 3; c++) begin
      #2;
      n_tests++;
      if (fu_claim !== '0) begin
        n_fail++; $display("FAIL bp_hold_claim c%0d: got %h expected 0", c, fu_claim);
      end
      step();
      for (int k = 0; k < EW; k++) begin
        n_tests++;
        if (exe_bundle[k].opid !== 16'(32'h8010 + k)) begin
          n_fail++; $display("FAIL bp_hold_slot%0d c%0d: got %h expected %h", k, c, exe_bundle[k].opid, 16'(32'h8010 + k));
        end
      end
      $display("[TB] back_pressure: hold cycle %0d", c);
    end
    execute = 4'b0101;
    #2;
    n_tests++;
    if (fu_claim !== 20'h00030) begin
      n_fail++; $display("FAIL bp_partial_claim: got %h expected %h", fu_claim, 20'h00030);
    end
    step();
    execute = '0;
    exp_op[0] = 16'h8020; exp_op[1] = 16'h8011; exp_op[2] = 16'h8021; exp_op[3] = 16'h8013;
    for (int k = 0; k < EW; k++) begin
      n_tests++;
      if (exe_bundle[k].opid !== exp_op[k]) begin
        n_fail++; $display("FAIL bp_partial_slot%0d: got %h expected %h", k, exe_bundle[k].opid, exp_op[k]);
      end
    end
    $display("[TB] back_pressure: execute=0101 refill");
  endtask

  task automatic test_oversub();
    logic [19:0] exp_claim;
    logic [15:0] base;
    do_reset();
    execute = '1;
    for (int l = 0; l < EW; l++) begin
      fu_resp[0][l] = mk(16'(32'h8100 + l));
      fu_resp[4][l] = mk(16'(32'h8400 + l));
    end
    for (int c = 0; c < 10; c++) begin
      exp_claim = (c % 5 == 0) ? 20'h0000F : 20'hF0000;
      base      = (c % 5 == 0) ? 16'h8100 : 16'h8400;
      #2;
      n_tests++;
      if (fu_claim !== exp_claim) begin
        n_fail++; $display("FAIL oversub_claim c%0d: got %h expected %h", c, fu_claim, exp_claim);
      end
      step();
      for (int k = 0; k < EW; k++) begin
        n_tests++;
        if (exe_bundle[k].opid !== base + 16'(k)) begin
          n_fail++; $display("FAIL oversub_slot%0d c%0d: got %h expected %h", k, c, exe_bundle[k].opid, base + 16'(k));
        end
      end
      $display("[TB] oversub: cycle %0d claim %h", c, exp_claim);
    end
    execute = '0;
  endtask

  task automatic test_starve();
    do_reset();
    for (int l = 0; l < EW; l++) fu_resp[0][l] = mk(16'(32'h8030 + l));
    step();
    clear_resp();
    fu_resp[2][0] = mk(16'h8200);
    for (int c = 0; c < 8; c++) begin
      #2;
      n_tests++;
      if (fu_claim !== '0) begin
        n_fail++; $display("FAIL starve_build_claim c%0d: got %h expected 0", c, fu_claim);
      end
      step();
    end
    for (int l = 0; l < EW; l++) fu_resp[3][l] = mk(16'(32'h8300 + l));
    execute = 4'b0001;
    #2;
    n_tests++;
    if (fu_claim !== 20'h00100) begin
      n_fail++; $display("FAIL starve_override_claim: got %h expected %h", fu_claim, 20'h00100);
    end
    step();
    n_tests++;
    if (exe_bundle[0].opid !== 16'h8200) begin
      n_fail++; $display("FAIL starve_override_slot0: got %h expected %h", exe_bundle[0].opid, 16'h8200);
    end
    n_tests++;
    if (exe_bundle[1].opid !== 16'h8031) begin
      n_fail++; $display("FAIL starve_hold_slot1: got %h expected %h", exe_bundle[1].opid, 16'h8031);
    end
    $display("[TB] starve: FU2 granted over ptr");
    clear_resp();
    fu_resp[2][0] = mk(16'h8201);
    fu_resp[4][0] = mk(16'h8401);
    #2;
    n_tests++;
    if (fu_claim !== 20'h10000) begin
      n_fail++; $display("FAIL starve_cleared_claim: got %h expected %h", fu_claim, 20'h10000);
    end
    step();
    n_tests++;
    if (exe_bundle[0].opid !== 16'h8401) begin
      n_fail++; $display("FAIL starve_cleared_slot0: got %h expected %h", exe_bundle[0].opid, 16'h8401);
    end
    $display("[TB] starve: counter cleared, ptr order resumes");
    execute = '0;
  endtask

  task automatic test_flush();
    do_reset();
    for (int l = 0; l < 3; l++) fu_resp[0][l] = mk(16'(32'h8050 + l));
    step();
    n_tests++;
    if (exe_bundle[2].opid !== 16'h8052 || exe_bundle[3].opid !== 16'h0000) begin
      n_fail++; $display("FAIL flush_setup: got %h/%h expected 8052/0000", exe_bundle[2].opid, exe_bundle[3].opid);
    end
    clear_resp();
    fu_resp[1][0] = mk(16'h8060);
    fu_resp[1][1] = mk(16'h8061);
    execute = '1;
    flush   = 1'b1;
    #2;
    n_tests++;
    if (fu_claim !== '0) begin
      n_fail++; $display("FAIL flush_claim: got %h expected 0", fu_claim);
    end
    step();
    flush = 1'b0;
    n_tests++;
    if (exe_bundle !== '0) begin
      n_fail++; $display("FAIL flush_bundle: got %h expected 0", exe_bundle);
    end
    $display("[TB] flush: slots dropped");
    clear_resp();
    for (int l = 0; l < EW; l++) fu_resp[0][l] = mk(16'(32'h8070 + l));
    fu_resp[1][0] = mk(16'h8080);
    #2;
    n_tests++;
    if (fu_claim !== 20'h0000F) begin
      n_fail++; $display("FAIL flush_ptr_hold_claim: got %h expected %h", fu_claim, 20'h0000F);
    end
    step();
    for (int k = 0; k < EW; k++) begin
      n_tests++;
      if (exe_bundle[k].opid !== 16'(32'h8070 + k)) begin
        n_fail++; $display("FAIL flush_after_slot%0d: got %h expected %h", k, exe_bundle[k].opid, 16'(32'h8070 + k));
      end
    end
    execute = '0;
  endtask

  task automatic test_accept_refill();
    do_reset();
    fu_resp[0][0] = mk(16'h8003);
    step();
    n_tests++;
    if (exe_bundle[0] !== mk(16'h8003)) begin
      n_fail++; $display("FAIL refill_setup: got %h expected %h", exe_bundle[0], mk(16'h8003));
    end
    clear_resp();
    fu_resp[1][0] = mk(16'h8007);
    execute = 4'b0001;
    #2;
    n_tests++;
    if (fu_claim !== 20'h00010) begin
      n_fail++; $display("FAIL refill_claim: got %h expected %h", fu_claim, 20'h00010);
    end
    step();
    n_tests++;
    if (exe_bundle[0] !== mk(16'h8007)) begin
      n_fail++; $display("FAIL refill_slot0: got %h expected %h", exe_bundle[0], mk(16'h8007));
    end
    fu_resp[1][0] = mk(16'h8008);
    step();
    n_tests++;
    if (exe_bundle[0] !== mk(16'h8008)) begin
      n_fail++; $display("FAIL refill_back_to_back: got %h expected %h", exe_bundle[0], mk(16'h8008));
    end
    n_tests++;
    if (exe_bundle[1] !== '0) begin
      n_fail++; $display("FAIL refill_slot1_empty: got %h expected 0", exe_bundle[1]);
    end
    $display("[TB] accept_refill: slot0 refilled each cycle");
    execute = '0;
    clear_resp();
  endtask

  initial begin
    fu_resp = '0;
    execute = '0;
    test_reset();
    test_back_pressure();
    test_oversub();
    test_starve();
    test_flush();
    test_accept_refill();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
